// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch program-counter controller for a pipelined MIPS
//               datapath. Selects PC+4, taken-branch, J/JAL or JR target,
//               holds under stall, buffers a redirect that arrives during a
//               stall, and drives the IF/ID flush.
//               Optional feature macro: BRANCH_DELAY_SLOT_EN (flush tied
//               to 0, delay-slot instruction executes).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [31:0] br_imm,
    input  logic        jmp_valid,
    input  logic [25:0] jmp_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        redirect_pending,
    output logic        misalign_err
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;

    logic        w_req;
    logic [31:0] w_br_off;
    logic [31:0] w_target;

    // Redirect request and its target, JR over J over taken branch
    always_comb begin
        w_br_off = br_imm << 2;
        w_req    = jr_valid | jmp_valid | (br_valid & br_taken);
        if (jr_valid) begin
            w_target = {jr_addr[31:2], 2'b00};
        end else if (jmp_valid) begin
            w_target = {br_pc4[31:28], jmp_index, 2'b00};
        end else begin
            w_target = br_pc4 + w_br_off;
        end
    end

    // Next-state, next-PC, flush and sticky misalignment logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        flush_d       = 1'b0;
        misalign_d    = misalign_q;
        case (state_q)
            S_RUN: begin
                if (jr_valid && (jr_addr[1:0] != 2'b00)) begin
                    misalign_d = 1'b1;
                end
                if (w_req) begin
                    if (stall) begin
                        // Pipeline frozen: park the target until the stall lifts
                        pend_target_d = w_target;
                        state_d       = S_PEND;
                    end else begin
                        pc_d    = w_target;
                        flush_d = 1'b1;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            S_PEND: begin
                // Redirect inputs are ignored here: the stalled pipeline may
                // keep presenting the same branch every cycle.
                if (!stall) begin
                    pc_d    = pend_target_q;
                    flush_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
`ifdef BRANCH_DELAY_SLOT_EN
        // Delay-slot instruction is architecturally executed, never killed
        flush_d = 1'b0;
`endif
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0000_0000;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc               = pc_q;
    assign pc_plus4         = pc_q + 32'd4;
    assign flush            = flush_q;
    assign redirect_pending = (state_q == S_PEND);
    assign misalign_err     = misalign_q;

endmodule
`default_nettype wire
